bank_patch_ctrl: RTL and testbench

//  Multi-channel breakpoint/bank-swap controller for the ZX81 core, in the buffer_clk domain.

---
 rtl/bank_patch_ctrl.sv | 128 ++++++++++++
 tb/tb_bank_patch_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_patch_ctrl.sv
// bank_patch_ctrl: breakpoint-triggered ROM-to-SRAM bank swap controller for the ZX81 core
module bank_patch_ctrl #(
  parameter int NUM_BP      = 4,
  parameter int ADDR_W      = 16,
  parameter int BANK_W      = 4,
  parameter int SYNC_STAGES = 2,
  localparam int IW         = NUM_BP > 1 ? $clog2(NUM_BP) : 1
) (
  input  logic              buffer_clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_mreq_n,
  input  logic              cpu_m1_n,
  input  logic              cfg_wr,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [BANK_W-1:0] cfg_bank,
  input  logic [1:0]        cfg_mode,
  input  logic [NUM_BP-1:0] arm,
  input  logic              abort,
  output logic              bank_e,
  output logic [BANK_W-1:0] bank_sel,
  output logic [IW-1:0]     active_ch,
  output logic              hit,
  output logic              cfg_err,
  output logic              busy
);
  localparam int SW = ADDR_W + 2;
  localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_HIT = 3'd2, S_SWAP = 3'd3, S_LEAVE = 3'd4, S_DISARM = 3'd5;
  localparam logic [1:0] M_REPEAT = 2'd1, M_HOLD = 2'd2;
  logic [SW-1:0]     sync_q [SYNC_STAGES];
  logic [ADDR_W-1:0] s_addr;
  logic              s_mreq_n, s_m1_n, fetch;
  logic [ADDR_W-1:0] bp_addr [NUM_BP];
  logic [BANK_W-1:0] bp_bank [NUM_BP];
  logic [1:0]        bp_mode [NUM_BP];
  logic [2:0]        state;
  logic              aborting, reject, match_any, repeat_m, hold_m, ch_arm, others_armed, ret_fetch;
  logic [IW-1:0]     match_idx;
  // address and strobes cross together so a fetch is never seen with a stale address
  always_ff @(posedge buffer_clk)
    if (!reset_n)
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= {{ADDR_W{1'b0}}, 2'b11};
    else begin
      sync_q[0] <= {cpu_addr, cpu_mreq_n, cpu_m1_n};
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  assign {s_addr, s_mreq_n, s_m1_n} = sync_q[SYNC_STAGES-1];
  assign fetch = !s_mreq_n && !s_m1_n;
  assign busy = !(state == S_IDLE || state == S_ARMED);
  assign reject = busy && cfg_idx == active_ch;
  always_ff @(posedge buffer_clk)
    if (!reset_n) begin
      cfg_err <= 1'b0;
      for (int k = 0; k < NUM_BP; k++) begin
        bp_addr[k] <= '0;
        bp_bank[k] <= '0;
        bp_mode[k] <= '0;
      end
    end else begin
      cfg_err <= cfg_wr && reject;
      if (cfg_wr && !reject && int'(cfg_idx) < NUM_BP) begin
        bp_addr[cfg_idx] <= cfg_addr;
        bp_bank[cfg_idx] <= cfg_bank;
        bp_mode[cfg_idx] <= cfg_mode;
      end
    end
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--)
      if (fetch && arm[i] && s_addr == bp_addr[i]) begin
        match_any = 1'b1;
        match_idx = IW'(i);
      end
  end
  assign repeat_m     = bp_mode[active_ch] == M_REPEAT;
  assign hold_m       = bp_mode[active_ch] == M_HOLD;
  assign ch_arm       = arm[active_ch];
  assign others_armed = |(arm & ~(NUM_BP'(1) << active_ch));
  assign ret_fetch    = fetch && s_addr == bp_addr[active_ch];
  always_ff @(posedge buffer_clk)
    if (!reset_n) begin
      state     <= S_IDLE;
      bank_e    <= 1'b0;
      bank_sel  <= '0;
      active_ch <= '0;
      hit       <= 1'b0;
      aborting  <= 1'b0;
    end else begin
      hit <= 1'b0;
      case (state)
        S_IDLE: if (|arm) state <= S_ARMED;
        S_ARMED:
          if (abort || !(|arm)) state <= S_IDLE;
          else if (match_any) begin
            state     <= S_HIT;
            active_ch <= match_idx;
            hit       <= 1'b1;
          end
        S_HIT:
          if (abort) begin
            state    <= S_LEAVE;
            aborting <= 1'b1;
          end else if (s_mreq_n) begin
            bank_e   <= 1'b1;
            bank_sel <= bp_bank[active_ch];
            state    <= S_SWAP;
          end
        S_SWAP:
          if (abort) begin
            state    <= S_LEAVE;
            aborting <= 1'b1;
          end else if (hold_m ? !ch_arm : ret_fetch) state <= S_LEAVE;
        S_LEAVE:
          if (s_mreq_n) begin
            bank_e   <= 1'b0;
            bank_sel <= '0;
            aborting <= 1'b0;
            state    <= (aborting || abort) ? S_IDLE : repeat_m ? S_ARMED : S_DISARM;
          end else if (abort) aborting <= 1'b1;
        S_DISARM:
          if (abort) state <= S_IDLE;
          else if (!ch_arm) state <= others_armed ? S_ARMED : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_bank_patch_ctrl.sv
// tb_bank_patch_ctrl: scoreboard bench; directed bus/config stimulus queues expected output events
module tb_bank_patch_ctrl;
  logic        buffer_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        cpu_mreq_n = 1'b1, cpu_m1_n = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [15:0] cfg_addr = '0;
  logic [3:0]  cfg_bank = '0;
  logic [1:0]  cfg_mode = '0;
  logic [3:0]  arm = '0;
  logic        abort = 1'b0;
  logic        bank_e, hit, cfg_err, busy;
  logic [3:0]  bank_sel;
  logic [1:0]  active_ch;
  int          total = 0, bad = 0, hit_count = 0;
  logic [15:0] exp_q [$];
  logic        mon_en = 1'b0;
  logic        m_q1 = 1'b1, m_q2 = 1'b1, last_s = 1'b1, last_rst_n = 1'b0;
  logic        prev_be = 1'b0;
  logic [3:0]  prev_bs = '0;

  bank_patch_ctrl dut (
    .buffer_clk(buffer_clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_mreq_n(cpu_mreq_n),
    .cpu_m1_n(cpu_m1_n), .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_bank(cfg_bank), .cfg_mode(cfg_mode), .arm(arm), .abort(abort), .bank_e(bank_e),
    .bank_sel(bank_sel), .active_ch(active_ch), .hit(hit), .cfg_err(cfg_err), .busy(busy)
  );

  always #5 buffer_clk = ~buffer_clk;

  // model of the two-stage MREQ synchroniser, used to police when bank_e may move
  always @(posedge buffer_clk) begin
    m_q1 <= cpu_mreq_n;
    m_q2 <= m_q1;
  end

  function automatic logic [15:0] ev_hit(input logic [1:0] ch);
    return {4'h1, 10'b0, ch};
  endfunction
  function automatic logic [15:0] ev_bank(input logic be, input logic [3:0] bs);
    return {4'h2, 7'b0, be, bs};
  endfunction
  localparam logic [15:0] EV_ERR = 16'h3000;

  task automatic pop_check(input logic [15:0] got, input string nm);
    logic [15:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected event got=%h", nm, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        bad++;
        $display("FAIL %s got=%h want=%h", nm, got, e);
      end
    end
  endtask

  always @(negedge buffer_clk) begin
    if (mon_en) begin
      if (hit === 1'b1) begin
        hit_count++;
        pop_check(ev_hit(active_ch), "hit");
      end
      if (cfg_err === 1'b1) pop_check(EV_ERR, "cfg_err");
      if (bank_e !== prev_be || bank_sel !== prev_bs) begin
        pop_check(ev_bank(bank_e, bank_sel), "bank");
        if (last_rst_n) begin
          total++;
          if (last_s !== 1'b1) begin
            bad++;
            $display("FAIL mreq_gap bank changed with s_mreq_n=%b want=1", last_s);
          end
        end
      end
    end
    prev_be    = bank_e;
    prev_bs    = bank_sel;
    last_s     = m_q2;
    last_rst_n = reset_n;
  end

  task automatic step(input int n);
    repeat (n) @(posedge buffer_clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic cfg(input logic [1:0] idx, input logic [15:0] a, input logic [3:0] b, input logic [1:0] m);
    cfg_wr = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_bank = b; cfg_mode = m;
    step(1);
    cfg_wr = 1'b0;
    step(1);
  endtask

  task automatic fetch(input logic [15:0] a);
    cpu_addr = a; cpu_mreq_n = 1'b0; cpu_m1_n = 1'b0;
    step(3);
    cpu_mreq_n = 1'b1; cpu_m1_n = 1'b1;
    step(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    step(3);
    check("rst_bank_e", {15'b0, bank_e}, 16'h0);
    check("rst_bank_sel", {12'b0, bank_sel}, 16'h0);
    check("rst_outs", {12'b0, hit, cfg_err, busy, |active_ch}, 16'h0);
    reset_n = 1'b1;
    mon_en = 1'b1;
    step(1);
    // 1: one-shot swap, then parked in DISARM until the arm bit drops
    cfg(2'd0, 16'h0352, 4'd1, 2'd0);
    arm = 4'b0001;
    step(2);
    exp_q.push_back(ev_hit(2'd0));
    exp_q.push_back(ev_bank(1'b1, 4'd1));
    fetch(16'h0352);
    check("t1_busy_swap", {15'b0, busy}, 16'h1);
    exp_q.push_back(ev_bank(1'b0, 4'd0));
    fetch(16'h0352);
    fetch(16'h0352);
    check("t1_busy_disarm", {15'b0, busy}, 16'h1);
    arm = 4'b0000;
    step(3);
    check("t1_idle", {15'b0, busy}, 16'h0);
    // 2: repeat mode re-arms itself three times
    cfg(2'd1, 16'h038B, 4'd2, 2'd1);
    arm = 4'b0010;
    step(2);
    hit_count = 0;
    for (int n = 0; n < 3; n++) begin
      exp_q.push_back(ev_hit(2'd1));
      exp_q.push_back(ev_bank(1'b1, 4'd2));
      fetch(16'h038B);
      exp_q.push_back(ev_bank(1'b0, 4'd0));
      fetch(16'h038B);
    end
    check("t2_hit_count", 16'(hit_count), 16'd3);
    arm = 4'b0000;
    step(3);
    // 3: hold mode ignores return fetches; arm drop mid-cycle waits for MREQ high
    cfg(2'd2, 16'h0200, 4'd3, 2'd2);
    arm = 4'b0100;
    step(2);
    exp_q.push_back(ev_hit(2'd2));
    exp_q.push_back(ev_bank(1'b1, 4'd3));
    fetch(16'h0200);
    fetch(16'h0200);
    fetch(16'h0200);
    check("t3_hold_bank_e", {15'b0, bank_e}, 16'h1);
    cpu_addr = 16'h0300; cpu_mreq_n = 1'b0; cpu_m1_n = 1'b0;
    step(3);
    arm = 4'b0000;
    step(3);
    check("t3_held_in_mreq", {15'b0, bank_e}, 16'h1);
    exp_q.push_back(ev_bank(1'b0, 4'd0));
    cpu_mreq_n = 1'b1; cpu_m1_n = 1'b1;
    step(5);
    check("t3_idle", {15'b0, busy}, 16'h0);
    // 4: two channels on the same address, lowest index wins
    cfg(2'd0, 16'h0100, 4'd5, 2'd0);
    cfg(2'd3, 16'h0100, 4'd9, 2'd0);
    arm = 4'b1001;
    step(2);
    exp_q.push_back(ev_hit(2'd0));
    exp_q.push_back(ev_bank(1'b1, 4'd5));
    fetch(16'h0100);
    check("t4_active_ch", {14'b0, active_ch}, 16'h0);
    // 5: owner rewrite rejected mid-swap, other channel rewrite accepted
    exp_q.push_back(EV_ERR);
    cfg(2'd0, 16'h0400, 4'hE, 2'd1);
    cfg(2'd3, 16'h0100, 4'd7, 2'd0);
    exp_q.push_back(ev_bank(1'b0, 4'd0));
    fetch(16'h0100);
    arm = 4'b1000;
    step(3);
    exp_q.push_back(ev_hit(2'd3));
    exp_q.push_back(ev_bank(1'b1, 4'd7));
    fetch(16'h0100);
    check("t5_active_ch3", {14'b0, active_ch}, 16'h3);
    exp_q.push_back(ev_bank(1'b0, 4'd0));
    fetch(16'h0100);
    arm = 4'b0000;
    step(3);
    arm = 4'b0001;
    step(2);
    exp_q.push_back(ev_hit(2'd0));
    exp_q.push_back(ev_bank(1'b1, 4'd5));
    fetch(16'h0100);
    // 6: abort inside a memory cycle tears down only once MREQ is high
    cpu_addr = 16'h0555; cpu_mreq_n = 1'b0; cpu_m1_n = 1'b0;
    step(3);
    abort = 1'b1;
    step(3);
    check("t6_abort_held", {15'b0, bank_e}, 16'h1);
    check("t6_abort_busy", {15'b0, busy}, 16'h1);
    exp_q.push_back(ev_bank(1'b0, 4'd0));
    cpu_mreq_n = 1'b1; cpu_m1_n = 1'b1;
    step(5);
    arm = 4'b0000;
    step(2);
    abort = 1'b0;
    step(1);
    check("t6_abort_idle", {15'b0, busy}, 16'h0);
    // reset mid-swap drops bank_e on the next edge and clears config
    arm = 4'b0001;
    step(2);
    exp_q.push_back(ev_hit(2'd0));
    exp_q.push_back(ev_bank(1'b1, 4'd5));
    fetch(16'h0100);
    exp_q.push_back(ev_bank(1'b0, 4'd0));
    reset_n = 1'b0;
    step(1);
    check("rst_mid_bank_e", {15'b0, bank_e}, 16'h0);
    step(2);
    check("rst_mid_busy", {15'b0, busy}, 16'h0);
    reset_n = 1'b1;
    step(2);
    exp_q.push_back(ev_hit(2'd0));
    exp_q.push_back(ev_bank(1'b1, 4'd0));
    fetch(16'h0000);
    arm = 4'b0000;
    exp_q.push_back(ev_bank(1'b0, 4'd0));
    abort = 1'b1;
    step(4);
    abort = 1'b0;
    step(2);
    check("end_busy", {15'b0, busy}, 16'h0);
    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
